// File: rtl/vx_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : vx_perf_counter_bank
// Description : Pipeline performance-counter bank. Event accumulators plus
//               request/response latency trackers, with saturate-or-wrap
//               arithmetic, sticky flags and an optional atomic snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_perf_counter_bank #(
    parameter int NUM_EVENTS = 8,
    parameter int NUM_LAT    = 2,
    parameter int INCR_BITS  = 4,
    parameter int CTR_BITS   = 44,
    parameter int OUTS_BITS  = 8,
    parameter bit SATURATE   = 1'b1,
    parameter bit SNAPSHOT   = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             clear,
    input  logic [NUM_EVENTS*INCR_BITS-1:0]  event_incr,
    input  logic [NUM_LAT-1:0]               lat_req,
    input  logic [NUM_LAT-1:0]               lat_rsp,
    input  logic                             snap_req,
    output logic                             snap_valid,
    output logic [NUM_EVENTS*CTR_BITS-1:0]   event_ctrs,
    output logic [NUM_LAT*CTR_BITS-1:0]      lat_totals,
    output logic [NUM_LAT*CTR_BITS-1:0]      lat_reqs,
    output logic [NUM_LAT*OUTS_BITS-1:0]     outstanding,
    output logic [NUM_EVENTS+2*NUM_LAT-1:0]  overflow,
    output logic [NUM_LAT-1:0]               underflow_err
);

    localparam int c_FLAG_BITS = NUM_EVENTS + 2*NUM_LAT;

    logic [NUM_EVENTS*CTR_BITS-1:0] w_live_event_ctrs;
    logic [NUM_LAT*CTR_BITS-1:0]    w_live_lat_totals;
    logic [NUM_LAT*CTR_BITS-1:0]    w_live_lat_reqs;
    logic [c_FLAG_BITS-1:0]         w_live_overflow;
    logic [NUM_LAT-1:0]             w_live_underflow;

    // The sum is formed one bit wider; the top bit is the carry-out.
    function automatic logic [CTR_BITS-1:0] f_acc_next(input logic [CTR_BITS:0] sum);
        if (sum[CTR_BITS] && SATURATE) begin
            return '1;
        end
        return sum[CTR_BITS-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Event accumulators
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_event
        logic [CTR_BITS-1:0] r_ctr;
        logic                r_ovf;
        logic [CTR_BITS:0]   w_sum;

        assign w_sum = {1'b0, r_ctr}
                     + {{(CTR_BITS+1-INCR_BITS){1'b0}}, event_incr[gi*INCR_BITS +: INCR_BITS]};

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_ctr <= '0;
                r_ovf <= 1'b0;
            end else if (clear) begin
                r_ctr <= '0;
                r_ovf <= 1'b0;
            end else if (enable) begin
                r_ctr <= f_acc_next(w_sum);
                r_ovf <= r_ovf | w_sum[CTR_BITS];
            end
        end

        assign w_live_event_ctrs[gi*CTR_BITS +: CTR_BITS] = r_ctr;
        assign w_live_overflow[gi]                        = r_ovf;
    end

    // ------------------------------------------------------------------------
    // Latency trackers
    // ------------------------------------------------------------------------
    for (genvar gj = 0; gj < NUM_LAT; gj++) begin : g_lat
        logic [OUTS_BITS-1:0] r_outs;
        logic [CTR_BITS-1:0]  r_total;
        logic [CTR_BITS-1:0]  r_reqs;
        logic                 r_ovf_total;
        logic                 r_ovf_reqs;
        logic                 r_unf;
        logic                 w_inc;
        logic                 w_dec;
        logic                 w_full;
        logic                 w_empty;
        logic [CTR_BITS:0]    w_total_sum;
        logic [CTR_BITS:0]    w_reqs_sum;

        // A simultaneous request and response leaves the count unchanged.
        assign w_inc   = lat_req[gj] & ~lat_rsp[gj];
        assign w_dec   = lat_rsp[gj] & ~lat_req[gj];
        assign w_full  = &r_outs;
        assign w_empty = (r_outs == '0);

        assign w_total_sum = {1'b0, r_total} + {{(CTR_BITS+1-OUTS_BITS){1'b0}}, r_outs};
        assign w_reqs_sum  = {1'b0, r_reqs}  + {{CTR_BITS{1'b0}}, lat_req[gj]};

        // Outstanding tracking is independent of enable and clear.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_outs <= '0;
            end else if (w_inc && !w_full) begin
                r_outs <= r_outs + 1'b1;
            end else if (w_dec && !w_empty) begin
                r_outs <= r_outs - 1'b1;
            end
        end

        // Uses the outstanding value from before this cycle's update, so a
        // request answered L cycles later contributes exactly L.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_total     <= '0;
                r_reqs      <= '0;
                r_ovf_total <= 1'b0;
                r_ovf_reqs  <= 1'b0;
                r_unf       <= 1'b0;
            end else if (clear) begin
                r_total     <= '0;
                r_reqs      <= '0;
                r_ovf_total <= 1'b0;
                r_ovf_reqs  <= 1'b0;
                r_unf       <= 1'b0;
            end else if (enable) begin
                r_total     <= f_acc_next(w_total_sum);
                r_reqs      <= f_acc_next(w_reqs_sum);
                r_ovf_total <= r_ovf_total | w_total_sum[CTR_BITS];
                r_ovf_reqs  <= r_ovf_reqs | w_reqs_sum[CTR_BITS] | (w_inc & w_full);
                r_unf       <= r_unf | (w_dec & w_empty);
            end
        end

        assign w_live_lat_totals[gj*CTR_BITS +: CTR_BITS]  = r_total;
        assign w_live_lat_reqs[gj*CTR_BITS +: CTR_BITS]    = r_reqs;
        assign w_live_overflow[NUM_EVENTS + gj]            = r_ovf_total;
        assign w_live_overflow[NUM_EVENTS + NUM_LAT + gj]  = r_ovf_reqs;
        assign w_live_underflow[gj]                        = r_unf;
        assign outstanding[gj*OUTS_BITS +: OUTS_BITS]      = r_outs;
    end

    // ------------------------------------------------------------------------
    // Output stage: shadow copy or live pass-through
    // ------------------------------------------------------------------------
    if (SNAPSHOT) begin : g_snap
        logic [NUM_EVENTS*CTR_BITS-1:0] r_sh_event_ctrs;
        logic [NUM_LAT*CTR_BITS-1:0]    r_sh_lat_totals;
        logic [NUM_LAT*CTR_BITS-1:0]    r_sh_lat_reqs;
        logic [c_FLAG_BITS-1:0]         r_sh_overflow;
        logic [NUM_LAT-1:0]             r_sh_underflow;
        logic                           r_snap_valid;

        // Shadows are never cleared; a clear in the snap cycle still
        // captures the pre-clear values.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sh_event_ctrs <= '0;
                r_sh_lat_totals <= '0;
                r_sh_lat_reqs   <= '0;
                r_sh_overflow   <= '0;
                r_sh_underflow  <= '0;
                r_snap_valid    <= 1'b0;
            end else begin
                r_snap_valid <= snap_req;
                if (snap_req) begin
                    r_sh_event_ctrs <= w_live_event_ctrs;
                    r_sh_lat_totals <= w_live_lat_totals;
                    r_sh_lat_reqs   <= w_live_lat_reqs;
                    r_sh_overflow   <= w_live_overflow;
                    r_sh_underflow  <= w_live_underflow;
                end
            end
        end

        assign snap_valid    = r_snap_valid;
        assign event_ctrs    = r_sh_event_ctrs;
        assign lat_totals    = r_sh_lat_totals;
        assign lat_reqs      = r_sh_lat_reqs;
        assign overflow      = r_sh_overflow;
        assign underflow_err = r_sh_underflow;
    end else begin : g_live
        logic w_unused_snap_req;

        assign w_unused_snap_req = snap_req;
        assign snap_valid        = 1'b0;
        assign event_ctrs        = w_live_event_ctrs;
        assign lat_totals        = w_live_lat_totals;
        assign lat_reqs          = w_live_lat_reqs;
        assign overflow          = w_live_overflow;
        assign underflow_err     = w_live_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_perf_counter_bank
// Description : Scoreboard bench; saturating, wrapping and snapshot instances
//               driven in parallel and compared against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_perf_counter_bank;

    localparam int NE = 4;
    localparam int NL = 2;
    localparam int IB = 4;
    localparam int CB = 8;
    localparam int OB = 3;
    localparam int NF = NE + 2*NL;
    localparam longint CMAX = (64'd1 << CB) - 1;
    localparam int     OMAX = (1 << OB) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, enable, clear, snap_req;
    logic [NE*IB-1:0] event_incr;
    logic [NL-1:0]    lat_req, lat_rsp;

    logic             sat_sv,  wrap_sv,  snp_sv;
    logic [NE*CB-1:0] sat_ev,  wrap_ev,  snp_ev;
    logic [NL*CB-1:0] sat_lt,  wrap_lt,  snp_lt;
    logic [NL*CB-1:0] sat_lr,  wrap_lr,  snp_lr;
    logic [NL*OB-1:0] sat_ou,  wrap_ou,  snp_ou;
    logic [NF-1:0]    sat_ov,  wrap_ov,  snp_ov;
    logic [NL-1:0]    sat_un,  wrap_un,  snp_un;

    vx_perf_counter_bank #(.NUM_EVENTS(NE), .NUM_LAT(NL), .INCR_BITS(IB), .CTR_BITS(CB),
                           .OUTS_BITS(OB), .SATURATE(1), .SNAPSHOT(0)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .event_incr(event_incr),
        .lat_req(lat_req), .lat_rsp(lat_rsp), .snap_req(snap_req), .snap_valid(sat_sv),
        .event_ctrs(sat_ev), .lat_totals(sat_lt), .lat_reqs(sat_lr), .outstanding(sat_ou),
        .overflow(sat_ov), .underflow_err(sat_un));

    vx_perf_counter_bank #(.NUM_EVENTS(NE), .NUM_LAT(NL), .INCR_BITS(IB), .CTR_BITS(CB),
                           .OUTS_BITS(OB), .SATURATE(0), .SNAPSHOT(0)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .event_incr(event_incr),
        .lat_req(lat_req), .lat_rsp(lat_rsp), .snap_req(snap_req), .snap_valid(wrap_sv),
        .event_ctrs(wrap_ev), .lat_totals(wrap_lt), .lat_reqs(wrap_lr), .outstanding(wrap_ou),
        .overflow(wrap_ov), .underflow_err(wrap_un));

    vx_perf_counter_bank #(.NUM_EVENTS(NE), .NUM_LAT(NL), .INCR_BITS(IB), .CTR_BITS(CB),
                           .OUTS_BITS(OB), .SATURATE(1), .SNAPSHOT(1)) u_snap (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .event_incr(event_incr),
        .lat_req(lat_req), .lat_rsp(lat_rsp), .snap_req(snap_req), .snap_valid(snp_sv),
        .event_ctrs(snp_ev), .lat_totals(snp_lt), .lat_reqs(snp_lr), .outstanding(snp_ou),
        .overflow(snp_ov), .underflow_err(snp_un));

    typedef struct packed {
        logic [NE*CB-1:0] ev;
        logic [NL*CB-1:0] lt;
        logic [NL*CB-1:0] lr;
        logic [NF-1:0]    ov;
        logic [NL-1:0]    un;
        logic [NL*OB-1:0] ou;
    } exp_t;

    typedef struct packed {
        exp_t sat;
        exp_t wrap;
    } live_t;

    live_t q_live[$];
    exp_t  q_snap[$];
    exp_t  last_snap;
    live_t mon_le;
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;

    // Reference model: index 0 saturates, index 1 wraps.
    longint        m_ev[2][NE];
    longint        m_lt[2][NL];
    longint        m_lr[2][NL];
    logic [NF-1:0] m_ov[2];
    logic [NL-1:0] m_un[2];
    int            m_outs[NL];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic acc(input int k, input longint v, input longint a, output longint r, output bit c);
        longint s;
        s = v + a;
        c = (s > CMAX);
        if (!c)          r = s;
        else if (k == 0) r = CMAX;
        else             r = s - (CMAX + 1);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NE; i++) m_ev[k][i] = 0;
            for (int j = 0; j < NL; j++) begin
                m_lt[k][j] = 0;
                m_lr[k][j] = 0;
            end
            m_ov[k] = '0;
            m_un[k] = '0;
        end
        for (int j = 0; j < NL; j++) m_outs[j] = 0;
    endtask

    task automatic model_step(input logic [NE*IB-1:0] inc, input logic [NL-1:0] rq,
                              input logic [NL-1:0] rs, input bit en, input bit clr);
        bit     c;
        longint r;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                for (int i = 0; i < NE; i++) m_ev[k][i] = 0;
                for (int j = 0; j < NL; j++) begin
                    m_lt[k][j] = 0;
                    m_lr[k][j] = 0;
                end
                m_ov[k] = '0;
                m_un[k] = '0;
            end else if (en) begin
                for (int i = 0; i < NE; i++) begin
                    acc(k, m_ev[k][i], longint'(inc[i*IB +: IB]), r, c);
                    m_ev[k][i] = r;
                    if (c) m_ov[k][i] = 1'b1;
                end
                for (int j = 0; j < NL; j++) begin
                    acc(k, m_lt[k][j], longint'(m_outs[j]), r, c);
                    m_lt[k][j] = r;
                    if (c) m_ov[k][NE+j] = 1'b1;
                    acc(k, m_lr[k][j], longint'(rq[j]), r, c);
                    m_lr[k][j] = r;
                    if (c) m_ov[k][NE+NL+j] = 1'b1;
                    if (rq[j] && !rs[j] && m_outs[j] == OMAX) m_ov[k][NE+NL+j] = 1'b1;
                    if (rs[j] && !rq[j] && m_outs[j] == 0)    m_un[k][j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < NL; j++) begin
            if (rq[j] && !rs[j] && m_outs[j] < OMAX)   m_outs[j]++;
            else if (rs[j] && !rq[j] && m_outs[j] > 0) m_outs[j]--;
        end
    endtask

    function automatic exp_t build(input int k);
        exp_t e;
        for (int i = 0; i < NE; i++) e.ev[i*CB +: CB] = m_ev[k][i][CB-1:0];
        for (int j = 0; j < NL; j++) begin
            e.lt[j*CB +: CB] = m_lt[k][j][CB-1:0];
            e.lr[j*CB +: CB] = m_lr[k][j][CB-1:0];
            e.ou[j*OB +: OB] = OB'(m_outs[j]);
        end
        e.ov = m_ov[k];
        e.un = m_un[k];
        return e;
    endfunction

    function automatic logic [NE*IB-1:0] inc0(input int v);
        logic [NE*IB-1:0] x;
        x = '0;
        x[IB-1:0] = IB'(v);
        return x;
    endfunction

    // One stimulus cycle: drive just after the edge, then record the
    // state the model predicts after the next edge.
    task automatic cycle(input logic [NE*IB-1:0] inc, input logic [NL-1:0] rq, input logic [NL-1:0] rs,
                         input bit en, input bit clr, input bit snp);
        live_t le;
        @(posedge clk);
        #2;
        event_incr = inc;
        lat_req    = rq;
        lat_rsp    = rs;
        enable     = en;
        clear      = clr;
        snap_req   = snp;
        if (snp) q_snap.push_back(build(0));
        model_step(inc, rq, rs, en, clr);
        le.sat  = build(0);
        le.wrap = build(1);
        q_live.push_back(le);
    endtask

    task automatic idle(input bit en);
        cycle('0, '0, '0, en, 1'b0, 1'b0);
    endtask

    task automatic cmp_set(input string tag, input exp_t e, input logic [NE*CB-1:0] ev,
                           input logic [NL*CB-1:0] lt, input logic [NL*CB-1:0] lr,
                           input logic [NF-1:0] ov, input logic [NL-1:0] un);
        check({tag, "_event_ctrs"}, 64'(ev), 64'(e.ev));
        check({tag, "_lat_totals"}, 64'(lt), 64'(e.lt));
        check({tag, "_lat_reqs"},   64'(lr), 64'(e.lr));
        check({tag, "_overflow"},   64'(ov), 64'(e.ov));
        check({tag, "_underflow"},  64'(un), 64'(e.un));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sat_ctrs"},   {sat_ev, sat_lt, sat_lr},    64'd0);
        check({tag, "_sat_misc"},   64'({sat_ov, sat_un, sat_ou, sat_sv}), 64'd0);
        check({tag, "_wrap_ctrs"},  {wrap_ev, wrap_lt, wrap_lr}, 64'd0);
        check({tag, "_wrap_misc"},  64'({wrap_ov, wrap_un, wrap_ou, wrap_sv}), 64'd0);
        check({tag, "_snp_ctrs"},   {snp_ev, snp_lt, snp_lr},    64'd0);
        check({tag, "_snp_misc"},   64'({snp_ov, snp_un, snp_ou, snp_sv}), 64'd0);
    endtask

    // Monitor: consumes one expected entry per cycle, and a snapshot entry
    // whenever the snapshot instance should be pulsing snap_valid.
    always @(posedge clk) begin
        #1;
        if (mon_en && q_live.size() > 0) begin
            mon_le = q_live.pop_front();
            cmp_set("sat", mon_le.sat, sat_ev, sat_lt, sat_lr, sat_ov, sat_un);
            check("sat_outstanding", 64'(sat_ou), 64'(mon_le.sat.ou));
            check("sat_snap_valid", 64'(sat_sv), 64'd0);
            cmp_set("wrap", mon_le.wrap, wrap_ev, wrap_lt, wrap_lr, wrap_ov, wrap_un);
            check("wrap_outstanding", 64'(wrap_ou), 64'(mon_le.wrap.ou));
            check("snp_outstanding", 64'(snp_ou), 64'(mon_le.sat.ou));
            check("snp_snap_valid", 64'(snp_sv), 64'(q_snap.size() > 0));
            if (q_snap.size() > 0) last_snap = q_snap.pop_front();
            cmp_set("snp", last_snap, snp_ev, snp_lt, snp_lr, snp_ov, snp_un);
        end
    end

    initial begin
        logic [NE*IB-1:0] inc;
        logic [NL-1:0]    rq, rs;
        int               preq, prsp;

        reset = 1'b0; enable = 1'b0; clear = 1'b0; snap_req = 1'b0;
        event_incr = '0; lat_req = '0; lat_rsp = '0;
        model_reset();
        last_snap = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Ten cycles of +3 on channel 0
        repeat (10) cycle(inc0(3), '0, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("dir_ev_30", 64'(sat_ev), 64'd30);
        check("dir_ovf_none", 64'(sat_ov), 64'd0);

        // Reach 250, then +9 crosses the 8-bit limit
        repeat (14) cycle(inc0(15), '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(inc0(10), '0, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("dir_ev_250", 64'(sat_ev[CB-1:0]), 64'd250);
        cycle(inc0(9), '0, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("dir_sat_255", 64'(sat_ev[CB-1:0]), 64'd255);
        check("dir_sat_ovf", 64'(sat_ov[0]), 64'd1);
        check("dir_wrap_3", 64'(wrap_ev[CB-1:0]), 64'd3);
        check("dir_wrap_ovf", 64'(wrap_ov[0]), 64'd1);

        // Requests at t0,t2; responses at t5,t6 -> total 5+4
        cycle('0, '0, '0, 1'b1, 1'b1, 1'b0);
        cycle('0, 2'b01, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        cycle('0, 2'b01, '0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        cycle('0, '0, 2'b01, 1'b1, 1'b0, 1'b0);
        cycle('0, '0, 2'b01, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("dir_lat_total_9", 64'(sat_lt[CB-1:0]), 64'd9);
        check("dir_lat_reqs_2", 64'(sat_lr[CB-1:0]), 64'd2);
        check("dir_outs_0", 64'(sat_ou[OB-1:0]), 64'd0);

        // Response with nothing outstanding on channel 1, then clear
        cycle('0, '0, 2'b10, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("dir_underflow_set", 64'(sat_un), 64'd2);
        check("dir_underflow_outs", 64'(sat_ou[2*OB-1:OB]), 64'd0);
        cycle('0, '0, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("dir_underflow_clr", 64'(sat_un), 64'd0);

        // Clear beats a same-cycle event; outstanding survives the clear
        cycle('0, 2'b01, '0, 1'b1, 1'b0, 1'b0);
        cycle(inc0(5), '0, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("dir_clr_ev", 64'(sat_ev), 64'd0);
        check("dir_clr_outs", 64'(sat_ou[OB-1:0]), 64'd1);
        check("dir_clr_lt0", 64'(sat_lt[CB-1:0]), 64'd0);
        idle(1'b1);
        check("dir_clr_lt1", 64'(sat_lt[CB-1:0]), 64'd1);
        cycle('0, '0, 2'b01, 1'b1, 1'b0, 1'b0);

        // Snapshot together with clear captures the pre-clear 40
        cycle('0, '0, '0, 1'b1, 1'b1, 1'b0);
        repeat (8) cycle(inc0(5), '0, '0, 1'b1, 1'b0, 1'b0);
        cycle('0, '0, '0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        check("dir_snap_40", 64'(snp_ev[CB-1:0]), 64'd40);
        check("dir_snap_valid", 64'(snp_sv), 64'd1);
        repeat (3) cycle(inc0(5), '0, '0, 1'b1, 1'b0, 1'b0);
        check("dir_snap_hold", 64'(snp_ev[CB-1:0]), 64'd40);
        check("dir_snap_pulse", 64'(snp_sv), 64'd0);

        // Randomised traffic; request-heavy first half, response-heavy second
        for (int n = 0; n < 400; n++) begin
            inc  = (NE*IB)'($urandom);
            preq = (n < 200) ? 55 : 25;
            prsp = (n < 200) ? 25 : 55;
            for (int j = 0; j < NL; j++) begin
                rq[j] = ($urandom_range(0, 99) < preq);
                rs[j] = ($urandom_range(0, 99) < prsp);
            end
            cycle(inc, rq, rs, $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 5) == 0);
        end

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_all_zero("async_reset");
        q_live.delete();
        q_snap.delete();
        model_reset();
        last_snap  = '0;
        enable     = 1'b0; clear = 1'b0; snap_req = 1'b0;
        event_incr = '0; lat_req = '0; lat_rsp = '0;
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int n = 0; n < 60; n++) begin
            inc = (NE*IB)'($urandom);
            for (int j = 0; j < NL; j++) begin
                rq[j] = ($urandom_range(0, 99) < 40);
                rs[j] = ($urandom_range(0, 99) < 40);
            end
            cycle(inc, rq, rs, $urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) == 0);
        end
        idle(1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("drain_live", 64'(q_live.size()), 64'd0);
        check("drain_snap", 64'(q_snap.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vx_perf_counter_bank.md
Name: VX_perf_counter_bank

Overview:
- Parametrised performance-counter generator and accumulator for the core pipeline.
- Accumulates NUM_EVENTS multi-bit event-count channels (stalls, uses, fetches).
- Tracks NUM_LAT request/response latency channels (ifetch, load, ...) by summing outstanding requests every cycle.
- Sits between the schedule/issue/LSU stages and the CSR/DCR perf readout, and replaces the hand-wired per-stage counters.
- Adds saturate-or-wrap arithmetic, sticky overflow flags, synchronous clear, an enable gate, and an optional atomic snapshot.

Parameters:
- NUM_EVENTS, 8, number of event accumulator channels (>=1)
- NUM_LAT, 2, number of latency tracker channels (>=1)
- INCR_BITS, 4, width of the per-cycle increment on each event channel
- CTR_BITS, 44, accumulator width (matches PERF_CTR_BITS)
- OUTS_BITS, 8, outstanding-request counter width per latency channel
- SATURATE, 1, 1 = accumulators clamp at all-ones; 0 = accumulators wrap modulo 2^CTR_BITS
- SNAPSHOT, 0, 0 = outputs track live values; 1 = outputs update only on snap_req

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- enable  input  1  accumulation gate; when 0, accumulators hold
- clear  input  1  synchronous zeroing of accumulators and flags
- event_incr  input  NUM_EVENTS*INCR_BITS  per-channel increment for this cycle
- lat_req  input  NUM_LAT  request fired this cycle
- lat_rsp  input  NUM_LAT  response fired this cycle
- snap_req  input  1  capture request (used only when SNAPSHOT=1)
- snap_valid  output  1  one-cycle pulse when the outputs were refreshed by a snapshot
- event_ctrs  output  NUM_EVENTS*CTR_BITS  event accumulators
- lat_totals  output  NUM_LAT*CTR_BITS  sum over cycles of the outstanding count
- lat_reqs  output  NUM_LAT*CTR_BITS  number of requests
- outstanding  output  NUM_LAT*OUTS_BITS  live outstanding count (never snapshotted)
- overflow  output  NUM_EVENTS+2*NUM_LAT  sticky flags; bit order: events, lat_totals, lat_reqs
- underflow_err  output  NUM_LAT  sticky flag: response seen with zero outstanding

Behaviour:
- Reset (reset=0, asynchronous): every register and every output goes to 0, including shadow registers, snap_valid, flags and outstanding.
- Event channel i, when enable=1 and clear=0:
  - ctr <= ctr + zero-extended event_incr[i], computed at CTR_BITS+1 width.
  - SATURATE=1, carry out: ctr <= all-ones and overflow[i] <= 1.
  - SATURATE=0, carry out: ctr takes the wrapped sum and overflow[i] <= 1.
- Outstanding channel j updates regardless of enable or clear:
  - req only: +1.
  - rsp only: -1.
  - req and rsp in the same cycle: unchanged.
  - req at all-ones: holds at all-ones and sets the lat_reqs overflow bit.
  - rsp at 0: holds at 0 and sets underflow_err[j].
- Latency channel j, when enable=1 and clear=0:
  - lat_total += outstanding value from before this cycle's update.
  - lat_reqs += lat_req[j].
  - Saturate/wrap and overflow rules are the same as for event channels.
  - A request issued at cycle t and answered at cycle t+L therefore contributes exactly L to lat_total.
- clear=1:
  - Next cycle: all accumulators, overflow and underflow_err are 0.
  - Same-cycle increments are discarded; clear wins over the event.
  - outstanding is NOT cleared.
  - Shadow registers are not cleared; in SNAPSHOT=1 mode they still need a snap_req to refresh.
- enable=0: accumulators and flags hold; outstanding still tracks.
- SNAPSHOT=0:
  - Outputs are the live registers, so a value is visible one cycle after the event cycle.
  - snap_valid stays 0.
- SNAPSHOT=1:
  - On a snap_req cycle, shadow registers capture the live accumulators and flags as they were before that cycle's update.
  - snap_valid is 1 on the following cycle, for exactly one cycle.
  - Back-to-back snap_req produces a pulse every cycle.
  - snap_req together with clear: the snapshot captures the pre-clear values.
- Latency: every output is registered, with one cycle from the input edge to output visibility.
- Width rules: increments are zero-extended; there is no sign handling; the outstanding arithmetic is OUTS_BITS wide.

Test Plan:
- Reset, then event_incr[0]=3 for 10 cycles with enable=1 -> event_ctrs[0]=30, all other channels 0, overflow=0.
- CTR_BITS=8, SATURATE=1, ctr preloaded to 250 via increments, then incr=9 -> ctr=255 and overflow[0]=1; with SATURATE=0 the same stimulus gives ctr=3 and overflow[0]=1.
- lat_req[0] at t=0 and t=2, lat_rsp[0] at t=5 and t=6 -> lat_totals[0]=9 (5+4), lat_reqs[0]=2, outstanding returns to 0.
- lat_rsp[1] with outstanding=0 -> underflow_err[1]=1, outstanding stays 0; a following clear -> underflow_err=0.
- clear asserted in the same cycle as event_incr=5 while a request is outstanding -> ctr=0 next cycle, outstanding stays 1, lat_totals resumes from 0 at +1 per cycle.
- SNAPSHOT=1: ctr live value 40, snap_req together with clear -> event_ctrs=40 and snap_valid=1 one cycle later; event_ctrs then stays 40 despite further events until the next snap_req.
- Asynchronous reset asserted mid-count between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
